// File: rtl/wb_write_queue.sv
// wb_write_queue
//   Selects one of NUM_INPUTS write-back sources, tags the result with a
//   destination register address and queues it in a DEPTH-entry FIFO. The
//   register bank drains the queue under a valid/ready handshake, so it may
//   stall without losing writes. Queued data can be forwarded by address, with
//   the youngest match winning. Writes to register 0 are accepted and dropped.
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   flush      synchronous queue clear (also clears sel_error)
//   selector   source index
//   data_in    flattened sources, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_addr    destination register of the incoming write
//   in_valid   producer has a write
//   in_ready   queue can accept (depends on occupancy only)
//   out_data   head entry data
//   out_addr   head entry address
//   out_valid  head entry present
//   out_ready  register bank consumes head
//   fwd_addr   forwarding lookup address
//   fwd_hit    a queued entry matches fwd_addr
//   fwd_data   data of the youngest matching entry
//   count      occupancy, 0..DEPTH
//   sel_error  sticky flag: a write was accepted with an illegal selector
module wb_write_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 6,
    parameter int SEL_WIDTH  = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [SEL_WIDTH-1:0]             selector,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0]            in_addr,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [ADDR_WIDTH-1:0]            out_addr,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic [ADDR_WIDTH-1:0]            fwd_addr,
    output logic                             fwd_hit,
    output logic [DATA_WIDTH-1:0]            fwd_data,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             sel_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [DEPTH-1:0]      mem_valid;

    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  sel_error_q;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_legal;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [PTR_W-1:0]      fwd_idx;

    // Source selection. An out-of-range selector yields zero data; the write
    // itself still proceeds and is flagged via sel_error.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, otherwise a latch is inferred.
        sel_data  = '0;
        sel_legal = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (selector == SEL_WIDTH'(k)) begin
                sel_data  = data_in[k*DATA_WIDTH +: DATA_WIDTH];
                sel_legal = 1'b1;
            end
        end
    end

    // in_ready looks only at occupancy, so the producer never sees a
    // combinational path through in_valid or out_ready.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign accept    = in_valid & in_ready;
    assign push      = accept & (in_addr != '0);
    assign pop       = out_valid & out_ready;

    // Gate with out_valid so the un-reset storage never leaks to the outputs.
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_addr  = out_valid ? mem_addr[rd_ptr] : '0;
    assign count     = count_q;
    assign sel_error = sel_error_q;

    // Entry payload storage.
    // NOTE: payload storage carries no reset; the per-entry valid bits below
    // are the only state that decides whether a slot's contents are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= sel_data;
            mem_addr[wr_ptr] <= in_addr;
        end
    end

    // Queue control: pointers, occupancy, valid bits and the sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples the pre-edge values of the others.
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            mem_valid   <= '0;
            sel_error_q <= 1'b0;
        end else if (flush) begin
            // Flush wins over any push or pop presented in the same cycle.
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            mem_valid   <= '0;
            sel_error_q <= 1'b0;
        end else begin
            // Push and pop never target the same slot: that would need the
            // queue to be both empty (for push) and non-empty (for pop) at once,
            // or full and accepting.
            if (push) begin
                mem_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                mem_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (accept && !sel_legal) begin
                sel_error_q <= 1'b1;
            end
        end
    end

    // Forwarding: walk from oldest (rd_ptr) to youngest so the last match
    // written is the youngest. Only committed entries take part; a write
    // being pushed this cycle is not yet visible, while the entry being
    // popped this cycle still is.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PTR_W'(i);
            if (fwd_addr != '0 && mem_valid[fwd_idx] &&
                mem_addr[fwd_idx] == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[fwd_idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed testbench for wb_write_queue with the default parameters
// (DATA_WIDTH=32, NUM_INPUTS=6, SEL_WIDTH=3, ADDR_WIDTH=5, DEPTH=4).
// Inputs change 1 ns after a rising edge; outputs are observed at that same
// point, i.e. well away from the active edge.
module tb_wb_write_queue;

    localparam int DW = 32;
    localparam int NI = 6;
    localparam int SW = 3;
    localparam int AW = 5;
    localparam int DP = 4;

    logic              clk;
    logic              reset;
    logic              flush;
    logic [SW-1:0]     selector;
    logic [NI*DW-1:0]  data_in;
    logic [AW-1:0]     in_addr;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic [AW-1:0]     out_addr;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     fwd_addr;
    logic              fwd_hit;
    logic [DW-1:0]     fwd_data;
    logic [2:0]        count;
    logic              sel_error;

    int tests_run;
    int tests_failed;

    wb_write_queue #(
        .DATA_WIDTH(DW), .NUM_INPUTS(NI), .SEL_WIDTH(SW),
        .ADDR_WIDTH(AW), .DEPTH(DP)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .selector(selector),
        .data_in(data_in), .in_addr(in_addr), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_addr(out_addr),
        .out_valid(out_valid), .out_ready(out_ready), .fwd_addr(fwd_addr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count),
        .sel_error(sel_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [DW-1:0] v);
        data_in[k*DW +: DW] = v;
    endtask

    // Present one write from source 0 carrying value v to register a.
    task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] v);
        selector = 3'd0;
        set_src(0, v);
        in_addr  = a;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; selector = '0; data_in = '0;
        in_addr = '0; in_valid = 1'b0; out_ready = 1'b0; fwd_addr = '0;
        step();
        step();
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: count=%0d out_valid=%b in_ready=%b, expected 0 0 1",
                     count, out_valid, in_ready);
        end
        tests_run++;
        if (out_data !== 32'h0 || out_addr !== 5'd0 || sel_error !== 1'b0 ||
            fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: out_data=%h out_addr=%0d sel_error=%b fwd_hit=%b fwd_data=%h, expected all 0",
                     out_data, out_addr, sel_error, fwd_hit, fwd_data);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        selector = 3'd2;
        set_src(2, 32'hDEADBEEF);
        in_addr  = 5'd8;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_addr !== 5'd8 || count !== 3'd1) begin
            tests_failed++;
            $display("FAIL single_push: valid=%b data=%h addr=%0d count=%0d, expected 1 deadbeef 8 1",
                     out_valid, out_data, out_addr, count);
        end
        for (int c = 0; c < 3; c++) begin
            set_src(2, 32'h0BAD0000 + c);
            step();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_addr !== 5'd8) begin
                tests_failed++;
                $display("FAIL single_hold%0d: valid=%b data=%h addr=%0d, expected 1 deadbeef 8",
                         c, out_valid, out_data, out_addr);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: count=%0d valid=%b, expected 0 0", count, out_valid);
        end
    endtask

    task automatic test_full_and_wrap();
        for (int a = 1; a <= 4; a++) push_one(AW'(a), 32'h100 + a);
        tests_run++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_state: count=%0d in_ready=%b, expected 4 0", count, in_ready);
        end
        push_one(5'd5, 32'h105);
        tests_run++;
        if (count !== 3'd4 || out_addr !== 5'd1) begin
            tests_failed++;
            $display("FAIL full_fifth_ignored: count=%0d head=%0d, expected 4 1", count, out_addr);
        end
        out_ready = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_addr !== AW'(a) || out_data !== 32'h100 + a) begin
                tests_failed++;
                $display("FAIL drain_order%0d: valid=%b addr=%0d data=%h, expected 1 %0d %h",
                         a, out_valid, out_addr, out_data, a, 32'h100 + a);
            end
            step();
        end
        out_ready = 1'b0;
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_empty: count=%0d valid=%b in_ready=%b, expected 0 0 1",
                     count, out_valid, in_ready);
        end
        // Pointers now sit at slot 1; three refills cross the wrap point.
        push_one(5'd6, 32'h206);
        push_one(5'd7, 32'h207);
        push_one(5'd11, 32'h20B);
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            ea = (j == 0) ? 5'd6 : (j == 1) ? 5'd7 : 5'd11;
            ed = (j == 0) ? 32'h206 : (j == 1) ? 32'h207 : 32'h20B;
            tests_run++;
            if (out_addr !== ea || out_data !== ed) begin
                tests_failed++;
                $display("FAIL wrap_order%0d: addr=%0d data=%h, expected %0d %h",
                         j, out_addr, out_data, ea, ed);
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_forward();
        push_one(5'd9, 32'h11);
        push_one(5'd9, 32'h22);
        fwd_addr = 5'd9;
        #1;
        tests_run++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin
            tests_failed++;
            $display("FAIL fwd_youngest: hit=%b data=%h, expected 1 22", fwd_hit, fwd_data);
        end
        fwd_addr = 5'd10;
        #1;
        tests_run++;
        if (fwd_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_miss: hit=%b, expected 0", fwd_hit);
        end
        fwd_addr = 5'd0;
        #1;
        tests_run++;
        if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL fwd_addr0: hit=%b data=%h, expected 0 0", fwd_hit, fwd_data);
        end
        // A write being pushed this cycle must not forward yet.
        fwd_addr = 5'd12;
        selector = 3'd0;
        set_src(0, 32'h33);
        in_addr  = 5'd12;
        in_valid = 1'b1;
        #1;
        tests_run++;
        if (fwd_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_push_invisible: hit=%b, expected 0", fwd_hit);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'h33 || count !== 3'd3) begin
            tests_failed++;
            $display("FAIL fwd_after_push: hit=%b data=%h count=%0d, expected 1 33 3",
                     fwd_hit, fwd_data, count);
        end
        push_one(5'd0, 32'h44);
        tests_run++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL addr0_dropped: count=%0d in_ready=%b, expected 3 1", count, in_ready);
        end
        // Drain the two addr-9 entries; the one being popped still forwards.
        out_ready = 1'b1;
        fwd_addr  = 5'd9;
        step();
        // Head is now the second addr-9 entry (0x22), popping this cycle.
        tests_run++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'h22 || out_data !== 32'h22) begin
            tests_failed++;
            $display("FAIL fwd_popping: hit=%b fwd=%h head=%h, expected 1 22 22",
                     fwd_hit, fwd_data, out_data);
        end
        step();
        out_ready = 1'b0;
        tests_run++;
        if (fwd_hit !== 1'b0 || count !== 3'd1) begin
            tests_failed++;
            $display("FAIL fwd_after_pop: hit=%b count=%0d, expected 0 1", fwd_hit, count);
        end
        fwd_addr = 5'd0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_sel_error();
        for (int k = 0; k < NI; k++) set_src(k, 32'hA5A50000 + k);
        selector = 3'd7;
        in_addr  = 5'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        selector = 3'd0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h0 || out_addr !== 5'd3 || sel_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL sel_illegal: valid=%b data=%h addr=%0d err=%b, expected 1 0 3 1",
                     out_valid, out_data, out_addr, sel_error);
        end
        push_one(5'd4, 32'h55);
        step();
        tests_run++;
        if (sel_error !== 1'b1 || count !== 3'd2) begin
            tests_failed++;
            $display("FAIL sel_sticky: err=%b count=%0d, expected 1 2", sel_error, count);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++;
        if (sel_error !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sel_flush: err=%b count=%0d valid=%b, expected 0 0 0",
                     sel_error, count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] seq [8];
        seq[0] = 32'hA0;
        seq[1] = 32'hA1;
        for (int k = 0; k < 6; k++) seq[k+2] = 32'hB0 + k;
        push_one(5'd20, 32'hA0);
        push_one(5'd21, 32'hA1);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            selector = 3'd0;
            set_src(0, 32'hB0 + k);
            in_addr  = AW'(22 + k);
            in_valid = 1'b1;
            tests_run++;
            if (out_data !== seq[k] || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_head%0d: data=%h in_ready=%b, expected %h 1",
                         k, out_data, in_ready, seq[k]);
            end
            step();
            tests_run++;
            if (count !== 3'd2) begin
                tests_failed++;
                $display("FAIL stream_count%0d: count=%0d, expected 2", k, count);
            end
        end
        // Flush together with a push (and a pop): all lost.
        flush = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_in_ready: in_ready=%b, expected 1", in_ready);
        end
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_push: count=%0d valid=%b, expected 0 0", count, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        push_one(5'd1, 32'h1);
        push_one(5'd2, 32'h2);
        push_one(5'd3, 32'h3);
        tests_run++;
        if (count !== 3'd3 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: count=%0d valid=%b, expected 3 1", count, out_valid);
        end
        #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b count=%0d data=%h, expected 0 0 0",
                     out_valid, count, out_data);
        end
        step();
        reset = 1'b1;
        step();
        tests_run++;
        if (count !== 3'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset: count=%0d in_ready=%b, expected 0 1", count, in_ready);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_full_and_wrap();
        test_forward();
        test_sel_error();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
